// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: mode encodings, FSM state type,
// Nk/Nr lookups, window base lookup and the GF(2^8) xtime helper.
package aes_pkg;

  localparam logic [1:0] AES128 = 2'h0;
  localparam logic [1:0] AES192 = 2'h2;
  localparam logic [1:0] AES256 = 2'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Key length in 32-bit words. 2'h1 is treated as AES128.
  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      AES192:  return 4'd6;
      AES256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  // Number of rounds.
  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      AES192:  return 4'd12;
      AES256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Index of the oldest live word in the 8-entry window, i.e. 8 - Nk.
  function automatic logic [2:0] win_base(input logic [1:0] m);
    case (m)
      AES192:  return 3'd2;
      AES256:  return 3'd0;
      default: return 3'd4;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Round-key stream between the key expander (master) and the round-key
// consumer (slave). A transfer happens on a rising edge where
// rk_valid && rk_ready.
//   rk_valid : master -> slave, rk_data/rk_idx hold a round key
//   rk_ready : slave  -> master, consumer accepts
//   rk_data  : 128-bit round key, first schedule word in [127:96]
//   rk_idx   : round-key number 0..Nr
interface aes_key_expand_if;

  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  modport master (
    output rk_valid,
    output rk_data,
    output rk_idx,
    input  rk_ready
  );

  modport slave (
    input  rk_valid,
    input  rk_data,
    input  rk_idx,
    output rk_ready
  );

endinterface

// File: rtl/sbox.sv
// AES forward S-box, purely combinational lookup.
//   data  : input byte
//   subst : substituted byte
module sbox (
  input  logic [7:0] data,
  output logic [7:0] subst
);

  // Entry 0x00 is the leftmost byte, so the table is indexed by ~data.
  localparam logic [255:0][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = TABLE[~data];

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128/192/256 key schedule. Produces one 32-bit schedule
// word per cycle from a sliding 8-word window and streams every group of
// four words as a 128-bit round key.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an expansion (sampled only when idle)
//   mode       : 0/1 AES128, 2 AES192, 3 AES256 (latched on start)
//   key_in     : left-aligned cipher key (latched on start)
//   busy       : expansion in progress
//   done       : one-cycle pulse after the last round key is accepted
//   rk         : round-key stream (master side)
module aes_key_expand
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [255:0]      key_in,
  output logic              busy,
  output logic              done,
  aes_key_expand_if.master  rk
);

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [7:0][31:0]   win_q;
  logic [5:0]         i_q;
  logic [2:0]         kcnt_q;      // i mod Nk, kept as a counter to avoid a divider
  logic [7:0]         rcon_q;
  logic [2:0][31:0]   collect_q;
  logic               rk_valid_q;
  logic [127:0]       rk_data_q;
  logic [3:0]         rk_idx_q;
  logic               busy_q, done_q;

  logic [3:0]         nk, nr;
  logic [2:0]         base, base_new;
  logic [5:0]         last_i;
  logic               key_phase, rot_path, sub_only, at_key;
  logic               transfer, stall;
  logic               load, advance, finish;
  logic [31:0]        sub_in, sub_out, temp, word;
  logic [7:0][31:0]   keyw;

  assign nk       = nk_of(mode_q);
  assign nr       = nr_of(mode_q);
  assign base     = win_base(mode_q);
  assign base_new = win_base(mode);
  assign last_i   = {nr, 2'b11};

  // keyw[k] is cipher-key word k (word 0 is the most significant).
  always_comb begin
    for (int k = 0; k < 8; k++) keyw[k] = key_in[255 - 32*k -: 32];
  end

  assign key_phase = (i_q < {2'b00, nk});
  assign rot_path  = !key_phase && (kcnt_q == 3'd0);
  assign sub_only  = !key_phase && (nk == 4'd8) && (kcnt_q == 3'd4);
  assign at_key    = (i_q[1:0] == 2'd3);
  assign transfer  = rk_valid_q && rk.rk_ready;
  assign stall     = at_key && rk_valid_q && !rk.rk_ready;

  // One S-box bank serves both RotWord+SubWord and the AES256 SubWord-only step.
  assign sub_in = rot_path ? {win_q[7][23:0], win_q[7][31:24]} : win_q[7];

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox u_sbox (
      .data  (sub_in[8*b +: 8]),
      .subst (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = win_q[7];
    if (rot_path)      temp = sub_out ^ {rcon_q, 24'h0};
    else if (sub_only) temp = sub_out;
  end

  // During the key phase the window is static and words are read in place.
  assign word = key_phase ? win_q[base + i_q[2:0]] : (win_q[base] ^ temp);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          advance = 1'b1;
          if (i_q == last_i) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (transfer) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= 2'h0;
      win_q      <= '0;
      i_q        <= '0;
      kcnt_q     <= '0;
      rcon_q     <= 8'h00;
      collect_q  <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;

      if (load) begin
        mode_q <= mode;
        // Key word k lands at win[8-Nk+k]; wrapped entries are don't-care.
        for (int j = 0; j < 8; j++) win_q[j] <= keyw[3'(j) - base_new];
        i_q    <= '0;
        kcnt_q <= '0;
        rcon_q <= 8'h01;
        busy_q <= 1'b1;
      end

      if (transfer) rk_valid_q <= 1'b0;

      if (advance) begin
        i_q    <= i_q + 6'd1;
        kcnt_q <= ({1'b0, kcnt_q} == nk - 4'd1) ? 3'd0 : kcnt_q + 3'd1;
        if (rot_path) rcon_q <= xtime(rcon_q);
        if (!key_phase) begin
          for (int j = 0; j < 7; j++) win_q[j] <= win_q[j+1];
          win_q[7] <= word;
        end
        if (at_key) begin
          rk_data_q  <= {collect_q[0], collect_q[1], collect_q[2], word};
          rk_idx_q   <= i_q[5:2];
          rk_valid_q <= 1'b1;
        end else begin
          collect_q[i_q[1:0]] <= word;
        end
      end

      if (finish) busy_q <= 1'b0;
    end
  end

  assign rk.rk_valid = rk_valid_q;
  assign rk.rk_data  = rk_data_q;
  assign rk.rk_idx   = rk_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'h0;
  logic [255:0] key_in = '0;
  logic         busy, done;

  aes_key_expand_if rk_if ();

  aes_key_expand dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .key_in (key_in),
    .busy   (busy),
    .done   (done),
    .rk     (rk_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  exp_t         expq[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           done_cnt = 0;
  int           xfer_cnt = 0;
  int           ready_pct = 100;
  logic [127:0] got_key[16];
  logic         held = 1'b0;
  logic [127:0] held_data;
  logic [3:0]   held_idx;
  logic [7:0]   sb[256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model (FIPS-197 style) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from the multiplicative inverse and the affine transform.
  initial begin
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      end
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic int nk_model(input logic [1:0] m);
    return (m == 2'h3) ? 8 : (m == 2'h2) ? 6 : 4;
  endfunction

  task automatic push_expected(input logic [1:0] m, input logic [255:0] k);
    int nk, nr;
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t e;
    nk = nk_model(m);
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) begin
      e.idx  = 4'(j);
      e.data = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
      expq.push_back(e);
    end
  endtask

  // ---------------- consumer ready generator ----------------
  initial begin
    rk_if.rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_if.rk_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (held) begin
        check("stall_valid", 128'(rk_if.rk_valid), 128'd1);
        check("stall_data", rk_if.rk_data, held_data);
        check("stall_idx", 128'(rk_if.rk_idx), 128'(held_idx));
      end
      held = 1'b0;
      if (rk_if.rk_valid) begin
        if (rk_if.rk_ready) begin
          if (expq.size() == 0) begin
            check("unexpected_key", 128'(rk_if.rk_idx), 128'hffff);
          end else begin
            exp_t e;
            e = expq.pop_front();
            check("rk_idx", 128'(rk_if.rk_idx), 128'(e.idx));
            check("rk_data", rk_if.rk_data, e.data);
            got_key[rk_if.rk_idx] = rk_if.rk_data;
            xfer_cnt++;
          end
        end else begin
          held      = 1'b1;
          held_data = rk_if.rk_data;
          held_idx  = rk_if.rk_idx;
        end
      end
    end
  end

  // Issue one expansion and wait for its done pulse. Called away from posedge.
  task automatic run_key(input logic [1:0] m, input logic [255:0] k);
    int d0, x0, nr;
    bit seen;
    nr = nk_model(m) + 6;
    for (int j = 0; j < 16; j++) got_key[j] = '0;
    push_expected(m, k);
    d0 = done_cnt;
    x0 = xfer_cnt;
    mode   = m;
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
    seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 128'(seen), 128'd1);
    check("done_count", 128'(done_cnt - d0), 128'd1);
    check("transfers", 128'(xfer_cnt - x0), 128'(nr + 1));
    check("busy_after_done", 128'(busy), 128'd0);
    check("queue_empty", 128'(expq.size()), 128'd0);
    expq.delete();
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    int d0;
    bit found;
    logic [255:0] k;

    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_valid", 128'(rk_if.rk_valid), 128'd0);
    check("reset_data", rk_if.rk_data, 128'd0);
    check("reset_idx", 128'(rk_if.rk_idx), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Known-answer runs, chained back-to-back with changing modes.
    run_key(AES128, KEY128);
    check("aes128_rk0", got_key[0], KEY128[255:128]);
    check("aes128_rk10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key(AES192, KEY192);
    check("aes192_rk12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
    run_key(AES256, KEY256);
    check("aes256_rk1", got_key[1], 128'h1f352c073b6108d72d9810a30914dff4);
    check("aes256_rk14", got_key[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Backpressure.
    ready_pct = 30;
    run_key(AES256, KEY256);
    check("bp_aes256_rk14", got_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
    run_key(AES256, rand_key());
    ready_pct = 100;

    // Ignored start mid-run, then asynchronous abort at round 5.
    push_expected(AES128, KEY128);
    d0 = done_cnt;
    mode = AES128; key_in = KEY128; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    mode = AES256; key_in = rand_key(); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (rk_if.rk_valid && rk_if.rk_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_round5", 128'(found), 128'd1);
    rst_n = 1'b0;
    #1;
    expq.delete();
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_valid", 128'(rk_if.rk_valid), 128'd0);
    check("abort_data", rk_if.rk_data, 128'd0);
    check("abort_idx", 128'(rk_if.rk_idx), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("no_done_after_abort", 128'(done_cnt - d0), 128'd0);
    check("idle_after_abort", 128'(busy), 128'd0);
    run_key(AES128, rand_key());

    // Randomized back-to-back runs across all mode encodings.
    for (int n = 0; n < 6; n++) begin
      ready_pct = $urandom_range(30, 100);
      k = rand_key();
      run_key(2'($urandom_range(0, 3)), k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
